// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program sequencer slice.
package prog_seq_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, RUN, FIN} seq_state_t;

  localparam int STATS_W = 16;

endpackage

// File: rtl/prog_sequencer_branch_lut.sv
// Branch-target register file: synchronous write/clear, asynchronous read.
module branch_lut #(
  parameter int L     = 10,
  parameter int LUT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             we,
  input  logic [LUT_W-1:0] waddr,
  input  logic [L-1:0]     wdata,
  input  logic [LUT_W-1:0] raddr,
  output logic [L-1:0]     rdata
);

  logic [2**LUT_W-1:0][L-1:0] mem;

  always_ff @(posedge Clk) begin
    if (Reset)   mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  // No write bypass: a same-cycle write is only visible after the edge.
  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_sequencer.sv
// Program sequencer: drives PC control, runs the Start/Done handshake, resolves branches via LUT.
// Optional taken-branch counter enabled by defining PROG_SEQ_STATS_EN.
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int             L      = 10,
  parameter int             LUT_W  = 4,
  parameter logic [L-1:0]   MAX_PC = {L{1'b1}}
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             BrReq,
  input  logic             BrCond,
  input  logic [LUT_W-1:0] BrIdx,
  input  logic             LutWe,
  input  logic [LUT_W-1:0] LutWAddr,
  input  logic [L-1:0]     LutWData,
  input  logic [L-1:0]     ProgCtr,
  output logic             PcReset,
  output logic             PcEn,
  output logic             BranchEn,
  output logic [L-1:0]     Target,
  output logic             Busy,
  output logic             Done
`ifdef PROG_SEQ_STATS_EN
  , output logic [STATS_W-1:0] TakenCnt
`endif
);

  seq_state_t   state;
  logic         run;
  logic [L-1:0] lut_rd;

  branch_lut #(.L(L), .LUT_W(LUT_W)) u_lut (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (LutWe),
    .waddr (LutWAddr),
    .wdata (LutWData),
    .raddr (BrIdx),
    .rdata (lut_rd)
  );

  assign run      = (state == RUN);
  assign PcReset  = (state == ARMED);
  assign PcEn     = run & ~Halt;
  assign BranchEn = run & BrReq & BrCond & ~Halt;
  assign Target   = run ? lut_rd : '0;

  // Busy/Done track the state register so they stay glitch-free Moore outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) state <= ARMED;
        ARMED: if (!Start) begin
          state <= RUN;
          Busy  <= 1'b1;
        end
        RUN: if (Halt || (ProgCtr == MAX_PC && !BranchEn)) begin
          state <= FIN;
          Busy  <= 1'b0;
          Done  <= 1'b1;
        end
        FIN: if (Start) begin
          state <= ARMED;
          Done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
          Done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PROG_SEQ_STATS_EN
  always_ff @(posedge Clk) begin
    if (Reset || state == ARMED)        TakenCnt <= '0;
    else if (BranchEn && ~&TakenCnt)    TakenCnt <= TakenCnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized + directed bench for prog_sequencer with a queue-based scoreboard.
module tb_prog_sequencer;

  localparam int           L      = 10;
  localparam int           LUT_W  = 4;
  localparam logic [9:0]   MAXPC  = 10'h010;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic             Reset, Start, Halt, BrReq, BrCond, LutWe;
  logic [LUT_W-1:0] BrIdx, LutWAddr;
  logic [L-1:0]     LutWData, ProgCtr;
  logic             PcReset, PcEn, BranchEn, Busy, Done;
  logic [L-1:0]     Target;
  logic [15:0]      taken_cnt;

  prog_sequencer #(.L(L), .LUT_W(LUT_W), .MAX_PC(MAXPC)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .BrReq(BrReq),
    .BrCond(BrCond), .BrIdx(BrIdx), .LutWe(LutWe), .LutWAddr(LutWAddr),
    .LutWData(LutWData), .ProgCtr(ProgCtr), .PcReset(PcReset), .PcEn(PcEn),
    .BranchEn(BranchEn), .Target(Target), .Busy(Busy), .Done(Done)
`ifdef PROG_SEQ_STATS_EN
    , .TakenCnt(taken_cnt)
`endif
  );

`ifndef PROG_SEQ_STATS_EN
  assign taken_cnt = '0;
`endif

  typedef struct {
    logic        pcreset, pcen, br, busy, done;
    logic [9:0]  target;
    logic [15:0] cnt;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: program phase as plain flags plus an array LUT.
  bit          m_armed, m_run, m_fin;
  logic [9:0]  m_lut [16];
  int unsigned m_cnt;

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, act, want, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("PcReset",  32'(PcReset),  32'(e.pcreset));
      chk("PcEn",     32'(PcEn),     32'(e.pcen));
      chk("BranchEn", 32'(BranchEn), 32'(e.br));
      chk("Target",   32'(Target),   32'(e.target));
      chk("Busy",     32'(Busy),     32'(e.busy));
      chk("Done",     32'(Done),     32'(e.done));
`ifdef PROG_SEQ_STATS_EN
      chk("TakenCnt", 32'(taken_cnt), 32'(e.cnt));
`endif
    end
  end

  task automatic model_reset();
    m_armed = 0; m_run = 0; m_fin = 0; m_cnt = 0;
    foreach (m_lut[i]) m_lut[i] = '0;
  endtask

  // Called at posedge+1 with inputs already applied; returns at the next posedge+1.
  task automatic go();
    exp_t e;
    bit take;
    take      = m_run && BrReq && BrCond && !Halt;
    e.pcreset = m_armed;
    e.pcen    = m_run && !Halt;
    e.br      = take;
    e.target  = m_run ? m_lut[BrIdx] : 10'h0;
    e.busy    = m_run;
    e.done    = m_fin;
    e.cnt     = 16'(m_cnt);
    q.push_back(e);
    if (Reset) model_reset();
    else begin
      if (LutWe) m_lut[LutWAddr] = LutWData;
      if (m_armed) m_cnt = 0;
      else if (take && m_cnt < 32'hFFFF) m_cnt++;
      if (m_run) begin
        if (Halt || (ProgCtr == MAXPC && !take)) begin m_run = 0; m_fin = 1; end
      end else if (m_armed) begin
        if (!Start) begin m_armed = 0; m_run = 1; end
      end else if (Start) begin
        m_fin = 0; m_armed = 1;
      end
    end
    @(posedge Clk); #1;
  endtask

  task automatic idle_in();
    Reset = 0; Start = 0; Halt = 0; BrReq = 0; BrCond = 0; BrIdx = '0;
    LutWe = 0; LutWAddr = '0; LutWData = '0; ProgCtr = '0;
  endtask

  task automatic arm_and_run();
    Start = 1; go(); go(); go();
    Start = 0; go();
  endtask

  initial begin
    idle_in();
    Reset = 1;
    repeat (2) @(posedge Clk);
    #1;
    model_reset();
    Reset = 0;

    // Reset state, then LUT preload while idle.
    go();
    LutWe = 1; LutWAddr = 4'd5; LutWData = 10'h07A; go();
    LutWe = 0;
    arm_and_run();

    // Taken and not-taken branches.
    BrReq = 1; BrCond = 1; BrIdx = 4'd5; ProgCtr = 10'h003; go();
    BrCond = 0; go();
    // Same-cycle write/read of index 3 returns old value, new value next cycle.
    BrCond = 1; BrIdx = 4'd3; LutWe = 1; LutWAddr = 4'd3; LutWData = 10'h100; go();
    LutWe = 0; go();
    BrIdx = 4'd5; go(); go();
    // Guard: taken branch at MAX_PC stays in RUN, untaken one finishes.
    ProgCtr = MAXPC; go();
    BrCond = 0; go();
    BrReq = 0; ProgCtr = '0; go(); go();

    // Halt beats a taken branch.
    arm_and_run();
    BrReq = 1; BrCond = 1; Halt = 1; go();
    idle_in(); go(); go();

    // Reset mid-run clears the LUT.
    arm_and_run();
    BrReq = 1; BrCond = 1; BrIdx = 4'd3; go();
    Reset = 1; go();
    Reset = 0; go();
    arm_and_run();
    go();
    idle_in(); go();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      Reset    = ($urandom_range(63) == 0);
      Start    = ($urandom_range(3) == 0);
      Halt     = ($urandom_range(15) == 0);
      BrReq    = $urandom_range(1);
      BrCond   = $urandom_range(1);
      BrIdx    = 4'($urandom);
      LutWe    = ($urandom_range(3) == 0);
      LutWAddr = 4'($urandom);
      LutWData = 10'($urandom);
      ProgCtr  = ($urandom_range(7) == 0) ? MAXPC : 10'($urandom_range(15));
      go();
    end
    idle_in(); go();

`ifdef PROG_SEQ_STATS_EN
    // Drive the counter to saturation, then re-arm to clear it.
    Reset = 1; go();
    Reset = 0; arm_and_run();
    BrReq = 1; BrCond = 1;
    for (int n = 0; n < 65540; n++) go();
    BrReq = 0; Halt = 1; go();
    Halt = 0; go();
    arm_and_run();
    go();
`endif

    idle_in();
    @(negedge Clk); @(negedge Clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
